// File: rtl/cpu_run_pkg.sv
// Shared types and default data-memory widths for the CPU run controller.
package cpu_run_pkg;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef enum logic [2:0] {IDLE, LOAD, CPU_RST, RUN, DRAIN, FINISH} state_t;
endpackage

// File: rtl/run_watchdog.sv
// Cycle counter for the RUN phase; expires on the limit-th enabled cycle (limit 0 disables).
module run_watchdog #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          expire
);
  logic [TW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + TW'(1);
  end

  assign expire = enable && (limit != '0) && (count == limit - TW'(1));
endmodule

// File: rtl/cpu_run_ctrl.sv
// Job sequencer: preload dmem from host, run the core under a watchdog, stream results back.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW,
  parameter int TW      = 16,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] in_base,
  input  logic [AW:0]   in_len,
  input  logic [AW-1:0] out_base,
  input  logic [AW:0]   out_len,
  input  logic [TW-1:0] timeout_lim,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          cpu_reset,
  output logic          cpu_req,
  input  logic          cpu_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          job_done,
  output logic          err_timeout
);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RST_CYC + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [RW-1:0] rst_cnt, rst_cnt_nx;
  logic          err_nx;
  logic          wd_expire;

  logic [AW-1:0] in_base_q, out_base_q;
  logic [CW-1:0] in_len_q, out_len_q;
  logic [TW-1:0] lim_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rst_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rst_cnt     <= rst_cnt_nx;
      err_timeout <= err_nx;
    end
  end

  // Job configuration is frozen at the accepted start; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_base_q  <= '0;
      in_len_q   <= '0;
      out_base_q <= '0;
      out_len_q  <= '0;
      lim_q      <= '0;
    end else if (state == IDLE && start) begin
      in_base_q  <= in_base;
      in_len_q   <= in_len;
      out_base_q <= out_base;
      out_len_q  <= out_len;
      lim_q      <= timeout_lim;
    end
  end

  run_watchdog #(.TW(TW)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != RUN),
    .enable (state == RUN),
    .limit  (lim_q),
    .expire (wd_expire)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    rst_cnt_nx  = rst_cnt;
    err_nx      = err_timeout;
    in_ready    = 1'b0;
    mem_own     = 1'b1;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    cpu_reset   = 1'b1;
    cpu_req     = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    job_done    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          err_nx     = 1'b0;
          cnt_nx     = '0;
          rst_cnt_nx = '0;
          state_nx   = (in_len == '0) ? CPU_RST : LOAD;
        end
      end
      LOAD: begin
        in_ready    = 1'b1;
        mem_addr    = in_base_q + cnt[AW-1:0];
        mem_wr_data = in_data;
        mem_wr_en   = in_valid;
        if (in_valid) begin
          if (cnt == in_len_q - CW'(1)) begin
            cnt_nx   = '0;
            state_nx = CPU_RST;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      CPU_RST: begin
        if (rst_cnt == RW'(RST_CYC - 1)) begin
          rst_cnt_nx = '0;
          state_nx   = RUN;
        end else begin
          rst_cnt_nx = rst_cnt + RW'(1);
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        cpu_req   = 1'b1;
        mem_own   = 1'b0;
        // A done arriving on the expiry cycle still counts as a clean finish.
        if (cpu_done) begin
          cnt_nx   = '0;
          state_nx = (out_len_q == '0) ? FINISH : DRAIN;
        end else if (wd_expire) begin
          err_nx   = 1'b1;
          state_nx = FINISH;
        end
      end
      DRAIN: begin
        mem_addr  = out_base_q + cnt[AW-1:0];
        out_data  = mem_rd_data;
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt == out_len_q - CW'(1)) begin
            cnt_nx   = '0;
            state_nx = FINISH;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      FINISH: begin
        job_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed plus randomized job sequences for cpu_run_ctrl against a transaction-level model.
module tb_cpu_run_ctrl;
  localparam int RST_CYC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_base = '0, out_base = '0;
  logic [8:0]  in_len = '0, out_len = '0;
  logic [15:0] timeout_lim = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_own, mem_wr_en;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data;
  logic        cpu_reset, cpu_req;
  logic        cpu_done = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy, job_done, err_timeout;

  logic [7:0]  dmem    [256];
  logic [7:0]  ref_mem [256];
  int          vectors = 0, miscompares = 0;

  logic [7:0]  j_in_base, j_out_base;
  logic [8:0]  j_in_len, j_out_len;
  logic [15:0] j_lim;

  always #5 clk = ~clk;

  assign mem_rd_data = dmem[mem_addr];
  always @(posedge clk) if (mem_own && mem_wr_en) dmem[mem_addr] <= mem_wr_data;

  cpu_run_ctrl #(.AW(8), .DW(8), .TW(16), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_base(in_base), .in_len(in_len), .out_base(out_base), .out_len(out_len),
    .timeout_lim(timeout_lim), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .cpu_reset(cpu_reset), .cpu_req(cpu_req), .cpu_done(cpu_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; config inputs are scrambled after the start pulse.
  task automatic start_job(input logic [7:0] ib, input logic [8:0] il, input logic [7:0] ob,
                           input logic [8:0] ol, input logic [15:0] lim);
    j_in_base = ib; j_in_len = il; j_out_base = ob; j_out_len = ol; j_lim = lim;
    in_base = ib; in_len = il; out_base = ob; out_len = ol; timeout_lim = lim;
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    in_base     = 8'($urandom);
    out_base    = 8'($urandom);
    in_len      = 9'($urandom_range(0, 256));
    out_len     = 9'($urandom_range(0, 256));
    timeout_lim = 16'($urandom_range(1, 3));
    check("start_busy", busy, 1'b1);
    check("start_err_clr", err_timeout, 1'b0);
    check("start_in_ready", in_ready, il != 0);
  endtask

  task automatic load_bytes(input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        #1 check("load_gap_wr", mem_wr_en, 1'b0);
        check("load_ready", in_ready, 1'b1);
        @(negedge clk);
      end
      a = j_in_base + 8'(i);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1 check("load_wr_en", mem_wr_en, 1'b1);
      check("load_addr", mem_addr, a);
      check("load_data", mem_wr_data, in_data);
      ref_mem[a] = in_data;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // done_after < 0: core never finishes. stall_at: result index that sees a 3-cycle stall.
  task automatic finish_job(input int done_after, input int stall_at);
    int n, r, k, g, st, exp_run;
    logic saw, bad, timed;
    logic [7:0] ea;
    n = 0; saw = 1'b0;
    while (!cpu_req && n < 50) begin
      if (in_ready || !cpu_reset || out_valid) saw = 1'b1;
      n++;
      @(negedge clk);
    end
    check("rst_cycles", n, RST_CYC);
    check("rst_quiet", saw, 1'b0);

    timed   = (j_lim != 0) && (done_after < 0 || done_after >= int'(j_lim));
    exp_run = timed ? int'(j_lim) : done_after + 1;
    r = 0; bad = 1'b0;
    while (cpu_req && r < 1000) begin
      if (cpu_reset || mem_own || out_valid) bad = 1'b1;
      cpu_done = (r == done_after);
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
      r++;
    end
    cpu_done = 1'b0;
    start    = 1'b0;
    check("run_cycles", r, exp_run);
    check("run_port", bad, 1'b0);

    if (!timed && j_out_len != 0) begin
      k = 0; g = 0; st = 0;
      while (k < int'(j_out_len) && g < 3000) begin
        ea = j_out_base + 8'(k);
        check("drain_valid", out_valid, 1'b1);
        check("drain_addr", mem_addr, ea);
        check("drain_data", out_data, ref_mem[ea]);
        if (out_valid !== 1'b1) break;
        if (k == stall_at && st < 3) begin
          out_ready = 1'b0;
          st++;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        g++;
        if (out_ready) k++;
      end
      out_ready = 1'b0;
      check("drain_count", k, j_out_len);
    end

    check("finish_pulse", job_done, 1'b1);
    check("finish_err", err_timeout, timed);
    check("finish_no_valid", out_valid, 1'b0);
    @(negedge clk);
    check("idle_pulse_end", job_done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_err_sticky", err_timeout, timed);
    check("idle_cpu_reset", cpu_reset, 1'b1);
  endtask

  initial begin
    int il, ol;
    #1;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_mem_own", mem_own, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_cpu_req", cpu_req, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a preload, then the same job again from scratch.
    start_job(8'h10, 9'd8, 8'h10, 9'd8, 16'd0);
    load_bytes(3);
    reset = 1'b0;
    #1 check("midload_cpu_reset", cpu_reset, 1'b1);
    check("midload_in_ready", in_ready, 1'b0);
    check("midload_busy", busy, 1'b0);
    check("midload_mem_own", mem_own, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_job(8'h10, 9'd8, 8'h10, 9'd8, 16'd0);
    load_bytes(8);
    finish_job(4, -1);

    // Address wrap at the top of memory.
    start_job(8'hFE, 9'd4, 8'hFE, 9'd4, 16'd100);
    load_bytes(4);
    finish_job(3, 1);

    // No input bytes, core done after 10 cycles, two results.
    start_job(8'h33, 9'd0, 8'h10, 9'd2, 16'd0);
    finish_job(9, -1);

    // Timeout with the core never finishing; the following start clears the flag.
    start_job(8'h60, 9'd2, 8'h60, 9'd2, 16'd5);
    load_bytes(2);
    finish_job(-1, -1);

    // Three-cycle consumer stall mid-drain.
    start_job(8'h40, 9'd6, 8'h40, 9'd6, 16'd0);
    load_bytes(6);
    finish_job(2, 2);

    // Done on the same cycle the watchdog expires.
    start_job(8'h50, 9'd3, 8'h50, 9'd3, 16'd6);
    load_bytes(3);
    finish_job(5, -1);

    // Full-memory job.
    start_job(8'h80, 9'd256, 8'h80, 9'd256, 16'd0);
    load_bytes(256);
    finish_job(7, 100);

    for (int j = 0; j < 4; j++) begin
      il = $urandom_range(1, 20);
      ol = $urandom_range(0, il);
      in_base = 8'($urandom);
      start_job(in_base, 9'(il), in_base, 9'(ol), 16'($urandom_range(0, 40)));
      load_bytes(il);
      finish_job($urandom_range(0, 30), $urandom_range(0, ol));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
